layer_mac_ctrl: RTL and testbench

LAYER_MAC_CTRL -- requirements
Module: layer_mac_ctrl

---
 rtl/layer_mac_ctrl.sv | 122 ++++++++++++
 tb/tb_layer_mac_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_ctrl.sv
// Streams one image of pixels against per-neuron weight memories and accumulates
// NUM_NEURONS signed dot products in parallel; results are published once the pass completes.
module layer_mac_ctrl #(
    parameter int unsigned NUM_INPUTS  = 784,
    parameter int unsigned NUM_NEURONS = 28,
    parameter int unsigned ACC_W       = 26,
    parameter int unsigned ADDR_W      = 11
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         PIX_VALID,
    input  logic [7:0]                   PIX_DATA,
    output logic                         PIX_READY,
    output logic                         EN,
    output logic                         WE,
    output logic [ADDR_W-1:0]            ADDR,
    input  logic [8*NUM_NEURONS-1:0]     W_IN,
    output logic [ACC_W*NUM_NEURONS-1:0] ACC_OUT,
    output logic                         OUT_VALID,
    output logic                         DONE,
    output logic                         BUSY
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

    state_e                               state_q, state_d;
    logic [ADDR_W-1:0]                    cnt_q;
    logic [7:0]                           pix_q;
    logic                                 mac_q;
    logic                                 out_valid_q;
    logic [NUM_NEURONS-1:0][ACC_W-1:0]    acc_q, acc_d, acc_out_q;
    logic signed [16:0]                   prod;
    logic                                 accept;
    logic                                 last_pix;

    assign accept   = PIX_VALID && (state_q == StRun);
    assign last_pix = (cnt_q == ADDR_W'(NUM_INPUTS - 1));

    assign EN   = accept;
    assign WE   = 1'b0;
    assign ADDR = cnt_q;

    // The freshly completed sums are visible during FINISH, before the copy into acc_out_q lands.
    assign ACC_OUT   = (state_q == StFinish) ? acc_q : acc_out_q;
    assign OUT_VALID = out_valid_q || (state_q == StFinish);

    always_comb begin
        state_d   = state_q;
        PIX_READY = 1'b0;
        DONE      = 1'b0;
        BUSY      = 1'b1;
        unique case (state_q)
            StIdle: begin
                BUSY = 1'b0;
                if (START) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                PIX_READY = 1'b1;
                if (accept && last_pix) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StFinish;
            end
            StFinish: begin
                DONE    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // W_IN arrives one cycle after EN, lined up with the registered pixel.
    always_comb begin
        prod  = '0;
        acc_d = acc_q;
        for (int n = 0; n < int'(NUM_NEURONS); n++) begin
            prod     = 17'($signed({1'b0, pix_q})) * 17'($signed(W_IN[8*n +: 8]));
            acc_d[n] = acc_q[n] + ACC_W'(prod);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pix_q       <= '0;
            mac_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            acc_out_q   <= '0;
        end else begin
            state_q <= state_d;
            mac_q   <= accept;
            if (state_q == StIdle && START) begin
                cnt_q       <= '0;
                acc_q       <= '0;
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                pix_q <= PIX_DATA;
                if (!last_pix) begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                end
            end
            if (mac_q) begin
                acc_q <= acc_d;
            end
            if (state_q == StFinish) begin
                acc_out_q   <= acc_q;
                out_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_mac_ctrl.sv
// Randomized bench for layer_mac_ctrl: a weight-memory model feeds W_IN and each pass's
// results are compared against dot products computed directly from the stimulus arrays.
module tb_layer_mac_ctrl;

    localparam int NI = 784;
    localparam int NN = 28;
    localparam int AW = 26;
    localparam int DW = 11;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              START = 1'b0;
    logic              PIX_VALID = 1'b0;
    logic [7:0]        PIX_DATA = '0;
    logic              PIX_READY;
    logic              EN;
    logic              WE;
    logic [DW-1:0]     ADDR;
    logic [8*NN-1:0]   W_IN = '0;
    logic [AW*NN-1:0]  ACC_OUT;
    logic              OUT_VALID;
    logic              DONE;
    logic              BUSY;

    layer_mac_ctrl #(
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN),
        .ACC_W      (AW),
        .ADDR_W     (DW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .PIX_VALID(PIX_VALID),
        .PIX_DATA (PIX_DATA),
        .PIX_READY(PIX_READY),
        .EN       (EN),
        .WE       (WE),
        .ADDR     (ADDR),
        .W_IN     (W_IN),
        .ACC_OUT  (ACC_OUT),
        .OUT_VALID(OUT_VALID),
        .DONE     (DONE),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    logic signed [7:0] w_mem [NN][NI];
    logic [7:0]        pix   [NI];
    longint            exp_acc [NN];
    longint            prev_acc [NN];
    bit                have_prev = 1'b0;

    int total = 0;
    int bad   = 0;

    // Synchronous-read weight memory: data appears the cycle after EN.
    always @(posedge CLK) begin
        if (EN) begin
            for (int n = 0; n < NN; n++) begin
                W_IN[8*n +: 8] <= w_mem[n][ADDR];
            end
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint acc_of(input int n);
        logic signed [AW-1:0] v;
        v = ACC_OUT[AW*n +: AW];
        return longint'(v);
    endfunction

    // mode 0: all ones, 1: full-scale negative, 2: random pixels and weights
    task automatic load_data(input int mode);
        for (int i = 0; i < NI; i++) begin
            case (mode)
                0:       pix[i] = 8'd1;
                1:       pix[i] = 8'd255;
                default: pix[i] = 8'($urandom_range(255));
            endcase
            for (int n = 0; n < NN; n++) begin
                case (mode)
                    0:       w_mem[n][i] = 8'sd1;
                    1:       w_mem[n][i] = -8'sd128;
                    default: w_mem[n][i] = 8'($urandom_range(255));
                endcase
            end
        end
        for (int n = 0; n < NN; n++) begin
            exp_acc[n] = 0;
            for (int i = 0; i < NI; i++) begin
                exp_acc[n] += longint'(pix[i]) * longint'(w_mem[n][i]);
            end
        end
    endtask

    // One image pass. vpct: percent chance PIX_VALID is high per cycle.
    // start_at / rst_at: pixel index at which to inject a stray START or a reset (-1 = none).
    task automatic do_pass(input string tag, input int vpct, input int start_at, input int rst_at);
        int idx = 0, cycles = 0, dones = 0, en_cnt = 0, addr_bad = 0;
        int last_cyc = -1, done_cyc = -1, after = 0;
        bit stray_done = 1'b0;

        if (have_prev) begin
            check({tag, ":hold_valid"}, longint'(OUT_VALID), 1);
            check({tag, ":hold_acc0"}, acc_of(0), prev_acc[0]);
        end
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        #1;
        check({tag, ":busy_after_start"}, longint'(BUSY), 1);
        check({tag, ":ovalid_cleared"}, longint'(OUT_VALID), 0);

        forever begin
            @(posedge CLK); #1;
            if (idx == rst_at) begin
                RST = 1'b1;
                PIX_VALID = 1'b0;
                @(posedge CLK); #1;
                RST = 1'b0;
                #1;
                check({tag, ":rst_busy"}, longint'(BUSY), 0);
                check({tag, ":rst_addr"}, longint'(ADDR), 0);
                check({tag, ":rst_ovalid"}, longint'(OUT_VALID), 0);
                check({tag, ":rst_ready"}, longint'(PIX_READY), 0);
                check({tag, ":rst_acc0"}, acc_of(0), 0);
                have_prev = 1'b0;
                return;
            end
            PIX_VALID = (idx < NI) && (int'($urandom_range(99)) < vpct);
            PIX_DATA  = (idx < NI) ? pix[idx] : 8'($urandom_range(255));
            START     = (idx == start_at) && !stray_done;
            if (START) stray_done = 1'b1;
            #1;
            if (PIX_READY && longint'(ADDR) != longint'(idx)) addr_bad++;
            if (EN) begin
                en_cnt++;
                last_cyc = cycles;
                idx++;
            end
            if (DONE) begin
                dones++;
                done_cyc = cycles;
                check({tag, ":ovalid_at_done"}, longint'(OUT_VALID), 1);
                for (int n = 0; n < NN; n++) begin
                    check($sformatf("%s:acc%0d", tag, n), acc_of(n), exp_acc[n]);
                end
            end
            cycles++;
            if (done_cyc >= 0) after++;
            if (after > 3 || cycles > 4000) break;
        end
        START = 1'b0;
        PIX_VALID = 1'b0;
        check({tag, ":no_timeout"}, longint'(done_cyc >= 0), 1);
        check({tag, ":done_count"}, longint'(dones), 1);
        check({tag, ":en_count"}, longint'(en_cnt), NI);
        check({tag, ":addr_seq_errs"}, longint'(addr_bad), 0);
        check({tag, ":done_latency"}, longint'(done_cyc - last_cyc), 2);
        check({tag, ":idle_busy"}, longint'(BUSY), 0);
        check({tag, ":idle_en"}, longint'(EN), 0);
        check({tag, ":ovalid_holds"}, longint'(OUT_VALID), 1);
        check({tag, ":acc_holds_last"}, acc_of(NN - 1), exp_acc[NN - 1]);
        for (int n = 0; n < NN; n++) prev_acc[n] = exp_acc[n];
        have_prev = 1'b1;
    endtask

    initial begin
        // START coincident with reset must be ignored.
        RST = 1'b1;
        START = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        START = 1'b0;
        RST = 1'b0;
        @(posedge CLK); #1;
        check("reset:busy", longint'(BUSY), 0);
        check("reset:addr", longint'(ADDR), 0);
        check("reset:ovalid", longint'(OUT_VALID), 0);
        check("reset:done", longint'(DONE), 0);
        check("reset:ready", longint'(PIX_READY), 0);
        check("reset:en", longint'(EN), 0);
        check("reset:we", longint'(WE), 0);
        check("reset:acc_out", longint'(ACC_OUT == '0), 1);

        load_data(0);
        do_pass("ones", 100, -1, -1);

        load_data(1);
        do_pass("fullscale", 100, -1, -1);
        check("fullscale:value", exp_acc[0], -64'sd25589760);

        load_data(2);
        do_pass("rand_cont", 100, -1, -1);
        do_pass("rand_stall", 50, -1, -1);

        do_pass("stray_start", 100, 100, -1);

        load_data(2);
        do_pass("midreset", 100, -1, 400);
        do_pass("after_reset", 70, -1, -1);

        // Back-to-back passes with fresh weights each time.
        load_data(2);
        do_pass("b2b_a", 100, -1, -1);
        load_data(2);
        do_pass("b2b_b", 100, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
